seg7_scan_ctrl: RTL
===================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed digits (2..8).
REQ-002 Parameter REFRESH_DIV, default 50000, SHALL set the number of clk cycles per digit slot (>= BLANK_CYCLES+2).
REQ-003 Parameter BLANK_CYCLES, default 4, SHALL set the dead-time in clk cycles between digit slots (>= 1).
REQ-004 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Port enable, input, 1, SHALL start scanning when high and stop it when low.
REQ-007 Port load, input, 1, SHALL request capture of bcd_in.
REQ-008 Port bcd_in, input, 4*NUM_DIGITS, SHALL carry the packed BCD digits, with digit 0 at bits [3:0].
REQ-009 Port load_ack, output, 1, SHALL pulse for one cycle to acknowledge a capture.
REQ-010 Port seg_bcd, output, 4, SHALL drive the bcdto7segment A..D inputs, with bit 3 driving A.
REQ-011 Port seg_en, output, 1, SHALL drive the bcdto7segment E input.
REQ-012 Port digit_sel, output, NUM_DIGITS, SHALL be the one-hot active-high digit strobe.

Function
REQ-013 The FSM SHALL have the states IDLE, BLANK and SHOW; the digit index idx SHALL run 0..NUM_DIGITS-1.
REQ-014 In IDLE, the FSM SHALL move to BLANK with idx=0 on the first cycle in which enable=1.
REQ-015 In BLANK, the FSM SHALL hold for exactly BLANK_CYCLES cycles and then move to SHOW.
REQ-016 In SHOW, the FSM SHALL hold until the slot counter reaches REFRESH_DIV-1, then increment idx (wrapping NUM_DIGITS-1 to 0) and move to BLANK.
REQ-017 The slot counter SHALL count from BLANK entry, so that one full slot (BLANK plus SHOW) equals REFRESH_DIV cycles.
REQ-018 enable=0 in any state SHALL force IDLE on the next edge and clear idx and the slot counter.
REQ-019 All outputs SHALL be registered.
REQ-020 In IDLE and BLANK, the outputs SHALL be digit_sel=0, seg_en=0 and seg_bcd=0.
REQ-021 On SHOW entry, the block SHALL latch digit_sel=1<<idx, seg_bcd=disp_reg[idx] and seg_en=1, and hold these values constant for the whole SHOW period.
REQ-022 A nibble value greater than 9 SHALL give seg_en=0 for that slot, while digit_sel still strobes.
REQ-023 A load=1 sampled on an edge SHALL copy bcd_in into disp_reg on that edge; load_ack SHALL be 1 on the following cycle.
REQ-024 A load held high SHALL capture on every cycle and produce an ack on every cycle.
REQ-025 A load arriving mid-SHOW SHALL NOT change the displayed digit; new data SHALL appear from the next SHOW entry.
REQ-026 When load and the slot end coincide, the next slot SHALL display the newly loaded data.
REQ-027 load SHALL be accepted in every state, including IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, idx=0, the slot counter to 0, disp_reg to 0, and digit_sel, seg_en, seg_bcd and load_ack to 0.
REQ-029 Reset asserted mid-scan SHALL blank the display in the same cycle, without waiting for a clock edge.
REQ-030 After rst_n deasserts, scanning SHALL restart from idx=0 via BLANK if enable=1.

Configuration
REQ-031 With SEG7_LZ_SUPPRESS_EN defined, digit idx (for idx>0) SHALL show seg_en=0 when its nibble and all higher-index nibbles are 0, and digit 0 SHALL always be shown.
REQ-032 With SEG7_LZ_SUPPRESS_EN undefined, every digit in the range 0..9 SHALL be shown, and no suppression logic SHALL be synthesized.

Structure
REQ-033 A package seg7_pkg SHALL hold the state enum typedef (IDLE/BLANK/SHOW), the BCD_MAX=9 constant and the default parameter constants.
REQ-034 A sub-module seg7_slot_timer SHALL implement the slot counter and provide blank_done and slot_end strobes to the FSM.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-035 The bench SHALL cover basic scan: load bcd_in=16'h4321, then enable=1 -> digit_sel follows 0001, 0010, 0100, 1000, 0001 with seg_bcd=1,2,3,4; each SHOW lasts 6 cycles and each BLANK lasts 2 cycles with all outputs 0.
REQ-036 The bench SHALL cover mid-SHOW load: load 16'h9999 during the SHOW of digit 1 showing 2 -> seg_bcd stays 2 until slot end, the next slot shows 9, and load_ack pulses once, one cycle after load.
REQ-037 The bench SHALL cover an invalid nibble: bcd_in=16'h00A0 -> during digit 1's slot, digit_sel=0010 and seg_en=0.
REQ-038 The bench SHALL cover reset mid-SHOW: rst_n=0 asynchronously -> all outputs are 0 before the next edge; after release with enable=1, the first strobe is 0001 after 2 blank cycles.
REQ-039 The bench SHALL cover enable drop: enable=0 during digit 2's SHOW -> outputs are 0 on the next edge; re-enable -> the scan restarts at digit 0.
REQ-040 The bench SHALL cover suppression: with SEG7_LZ_SUPPRESS_EN defined and bcd_in=16'h0050 -> digits 3 and 2 show seg_en=0, while digit 1 shows 5 and digit 0 shows 0; without the macro, all four digits show seg_en=1.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan controller.
//   seg7_state_e      - scan FSM state encoding (IDLE / BLANK / SHOW)
//   BCD_MAX           - largest nibble that is shown as a decimal digit
//   DEF_*             - default parameter values for the controller
//   bcd_valid()       - true when a nibble is a displayable BCD digit
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } seg7_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_REFRESH_DIV  = 50000;
  localparam int DEF_BLANK_CYCLES = 4;

  function automatic logic bcd_valid(input logic [3:0] nib);
    return nib <= BCD_MAX;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: per-slot cycle counter for the scan controller.
// A slot is REFRESH_DIV cycles long and starts at BLANK entry; the first
// BLANK_CYCLES counts are dead-time, the remainder is the SHOW window.
//   clk, rst_n  - clock, async active-low reset
//   run         - count while high; low holds the counter at 0
//   blank_done  - last cycle of the dead-time (count == BLANK_CYCLES-1)
//   slot_end    - last cycle of the slot (count == REFRESH_DIV-1)
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic blank_done,
  output logic slot_end
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign blank_done = (cnt_q == CW'(BLANK_CYCLES - 1));
  assign slot_end   = (cnt_q == CW'(REFRESH_DIV - 1));

  // Wraps to 0 at slot end so the next slot starts counting at BLANK entry.
  always_comb begin
    cnt_d = '0;
    if (run && !slot_end) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a NUM_DIGITS-digit
// 7-segment display driven through an external BCD-to-7-segment decoder.
//   clk, rst_n   - clock, async active-low reset
//   enable       - scan runs while high; low returns to IDLE
//   load, bcd_in - capture packed BCD digits (digit 0 at bits [3:0])
//   load_ack     - one-cycle acknowledge, the cycle after each capture
//   seg_bcd      - decoder A..D (bit 3 = A)
//   seg_en       - decoder E (low blanks invalid / suppressed digits)
//   digit_sel    - one-hot active-high digit strobe
// Optional build macro: SEG7_LZ_SUPPRESS_EN blanks leading-zero digits
// (digit 0 is always shown).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    load_ack,
  output logic [3:0]              seg_bcd,
  output logic                    seg_en,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int IW = $clog2(NUM_DIGITS);

  seg7_state_e                  state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]   disp_q, disp_d;
  logic [NUM_DIGITS-1:0]        digit_sel_q, digit_sel_d;
  logic [3:0]                   seg_bcd_q, seg_bcd_d;
  logic                         seg_en_q, seg_en_d;
  logic                         load_ack_q, load_ack_d;
  logic                         blank_done, slot_end, run;
  logic [3:0]                   nib;
  logic                         show_en;

  assign run = enable && (state_q != IDLE);

  seg7_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .blank_done (blank_done),
    .slot_end   (slot_end)
  );

  // Display register; accepted in every state.
  assign disp_d     = load ? bcd_in : disp_q;
  assign load_ack_d = load;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
        end
        BLANK: if (blank_done) state_d = SHOW;
        SHOW: if (slot_end) begin
          state_d = BLANK;
          idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Digit data is taken from disp_d so a load on the SHOW-entry edge is
  // already visible in the slot it opens.
  assign nib = disp_d[idx_q];

`ifdef SEG7_LZ_SUPPRESS_EN
  // lz[i]: nibble i and every higher-index nibble are zero.
  logic [NUM_DIGITS-1:0] lz;
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = (disp_d[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      lz[i] = lz[i+1] && (disp_d[i] == 4'd0);
  end
  assign show_en = bcd_valid(nib) && !((idx_q != '0) && lz[idx_q]);
`else
  assign show_en = bcd_valid(nib);
`endif

  // Output logic: latch on SHOW entry, hold through SHOW, zero elsewhere.
  always_comb begin
    digit_sel_d = '0;
    seg_bcd_d   = '0;
    seg_en_d    = 1'b0;
    if (state_d == SHOW) begin
      if (state_q == SHOW) begin
        digit_sel_d = digit_sel_q;
        seg_bcd_d   = seg_bcd_q;
        seg_en_d    = seg_en_q;
      end else begin
        digit_sel_d = NUM_DIGITS'(1) << idx_q;
        seg_bcd_d   = nib;
        seg_en_d    = show_en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q      <= '0;
      digit_sel_q <= '0;
      seg_bcd_q   <= '0;
      seg_en_q    <= 1'b0;
      load_ack_q  <= 1'b0;
    end else begin
      disp_q      <= disp_d;
      digit_sel_q <= digit_sel_d;
      seg_bcd_q   <= seg_bcd_d;
      seg_en_q    <= seg_en_d;
      load_ack_q  <= load_ack_d;
    end
  end

  assign digit_sel = digit_sel_q;
  assign seg_bcd   = seg_bcd_q;
  assign seg_en    = seg_en_q;
  assign load_ack  = load_ack_q;

endmodule
